sx_bus_bridge: RTL and testbench

- Parametrised successor to the 386SX northbridge bus front end.
- Samples CPU bus cycles (ADS#, M/IO#, D/C#, W/R#, BHE#/BLE#) and decodes them against N_REG programmable regions.
- Runs each cycle as either a fixed-wait-state internal access or an Avalon-style external handshake (SDRAM).
- Generates READY#, with a timeout watchdog, halt/shutdown acknowledge and a bus-error flag.

---
 rtl/sx_bus_pkg.sv | 35 +++
 rtl/sx_bus_bridge_if.sv | 28 ++
 rtl/sx_addr_decode.sv | 46 ++++
 rtl/sx_bus_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_sx_bus_bridge.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sx_bus_pkg.sv
// sx_bus_pkg: shared encodings for the 386SX bus bridge.
// State codes, cycle codes and fixed bus constants.
package sx_bus_pkg;

  localparam logic [5:0] ST_IDLE     = 6'b000001;
  localparam logic [5:0] ST_DECODE   = 6'b000010;
  localparam logic [5:0] ST_WAIT     = 6'b000100;
  localparam logic [5:0] ST_EXT_REQ  = 6'b001000;
  localparam logic [5:0] ST_EXT_RESP = 6'b010000;
  localparam logic [5:0] ST_READY    = 6'b100000;

  typedef enum logic [5:0] {
    IDLE     = ST_IDLE,
    DECODE   = ST_DECODE,
    WAIT     = ST_WAIT,
    EXT_REQ  = ST_EXT_REQ,
    EXT_RESP = ST_EXT_RESP,
    READY    = ST_READY
  } state_t;

  // {mio, dc, wr} of a halt/shutdown special cycle
  localparam logic [2:0] HALT_CYC = 3'b101;

  localparam logic [15:0] FILL_DATA = 16'hFFFF;

  // READY# low time in clk periods (one CPU bus clock)
  localparam logic [1:0] READY_LEN = 2'd2;

  function automatic logic is_halt(
    input logic [2:0] cyc
  );
    return cyc == HALT_CYC;
  endfunction

endpackage

// File: rtl/sx_bus_bridge_if.sv
// sx_bus_bridge_if: 386SX CPU-side bus bundle.
// master = CPU side, slave = bridge side.
interface sx_bus_bridge_if;

  logic        ads_n;
  logic        mio;
  logic        dc;
  logic        wr;
  logic [1:0]  be_n;
  logic [22:0] addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        data_oe;
  logic        ready_n;

  modport master (
    output ads_n, mio, dc, wr,
    output be_n, addr, cpu_wdata,
    input  cpu_rdata, data_oe, ready_n
  );

  modport slave (
    input  ads_n, mio, dc, wr,
    input  be_n, addr, cpu_wdata,
    output cpu_rdata, data_oe, ready_n
  );

endinterface

// File: rtl/sx_addr_decode.sv
// sx_addr_decode: region matcher with lowest-index priority.
// Purely combinational; the bridge latches its result.
module sx_addr_decode
  import sx_bus_pkg::*;
#(
  parameter int                 N_REG    = 4,
  parameter logic [N_REG*24-1:0] REG_BASE = {N_REG{24'h0}},
  parameter logic [N_REG*24-1:0] REG_MASK = {N_REG{24'h0}},
  parameter logic [N_REG-1:0]    REG_IO   = {N_REG{1'b0}}
) (
  input  logic [22:0]      addr,
  input  logic             mio,
  output logic [N_REG-1:0] hit,
  output logic             any_hit
);

  logic [23:0]      byte_addr;
  logic [N_REG-1:0] match;

  assign byte_addr = {addr, 1'b0};

  // per-region compare; I/O regions only see mio=0 cycles
  always_comb begin
    match = '0;
    for (int i = 0; i < N_REG; i++) begin
      match[i] =
        ((byte_addr & REG_MASK[i*24 +: 24]) ==
         (REG_BASE[i*24 +: 24] & REG_MASK[i*24 +: 24]))
        && (REG_IO[i] == !mio);
    end
  end

  // scan downwards so the lowest matching index ends up set
  always_comb begin
    hit = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
  end

  assign any_hit = |match;

endmodule

// File: rtl/sx_bus_bridge.sv
// sx_bus_bridge: 386SX bus front end with region decode,
// fixed-wait or Avalon-style external cycles and a watchdog.
module sx_bus_bridge
  import sx_bus_pkg::*;
#(
  parameter int                  N_REG    = 4,
  parameter logic [N_REG*24-1:0] REG_BASE = {N_REG{24'h0}},
  parameter logic [N_REG*24-1:0] REG_MASK = {N_REG{24'h0}},
  parameter logic [N_REG-1:0]    REG_IO   = {N_REG{1'b0}},
  parameter logic [N_REG-1:0]    REG_EXT  = {N_REG{1'b0}},
  parameter logic [N_REG*4-1:0]  REG_WAIT = {N_REG{4'd0}},
  parameter logic [3:0]          DEF_WAIT = 4'd1,
  parameter logic [7:0]          TIMEOUT  = 8'd255
) (
  input  logic                clk,
  input  logic                reset,
  sx_bus_bridge_if.slave      cpu,
  output logic [N_REG-1:0]    s_sel,
  output logic [22:0]         s_addr,
  output logic [1:0]          s_be_n,
  output logic [15:0]         s_wdata,
  output logic                s_rd,
  output logic                s_wr,
  input  logic [N_REG*16-1:0] s_rdata,
  input  logic [N_REG-1:0]    s_waitrequest,
  input  logic [N_REG-1:0]    s_valid,
  output logic                bus_err,
  output logic                halt,
  output logic                busy
);

  state_t           state;
  logic [2:0]       cyc_q;
  logic             miss_q;
  logic [3:0]       wcnt;
  logic [7:0]       wdog;
  logic [1:0]       rlen;

  logic [N_REG-1:0] hit;
  logic             any_hit;
  logic             wr_q;
  logic             halt_q;
  logic             tmo;

  logic [15:0]      sel_rdata;
  logic [3:0]       sel_wait;
  logic             sel_ext;
  logic             sel_wreq;
  logic             sel_valid;

  sx_addr_decode #(
    .N_REG    (N_REG),
    .REG_BASE (REG_BASE),
    .REG_MASK (REG_MASK),
    .REG_IO   (REG_IO)
  ) u_dec (
    .addr    (cpu.addr),
    .mio     (cpu.mio),
    .hit     (hit),
    .any_hit (any_hit)
  );

  assign wr_q   = cyc_q[0];
  assign halt_q = is_halt(cyc_q);
  assign tmo    = (wdog + 8'd1) == TIMEOUT;
  assign busy   = state != IDLE;

  // route the selected region's attributes and slave signals
  always_comb begin
    sel_rdata = '0;
    sel_wait  = '0;
    sel_ext   = 1'b0;
    sel_wreq  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < N_REG; i++) begin
      if (s_sel[i]) begin
        sel_rdata = sel_rdata | s_rdata[i*16 +: 16];
        sel_wait  = sel_wait | REG_WAIT[i*4 +: 4];
        sel_ext   = sel_ext | REG_EXT[i];
        sel_wreq  = sel_wreq | s_waitrequest[i];
        sel_valid = sel_valid | s_valid[i];
      end
    end
  end

  // bus-cycle FSM; every output is registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cyc_q         <= '0;
      miss_q        <= 1'b0;
      s_sel         <= '0;
      s_addr        <= '0;
      s_be_n        <= '0;
      s_wdata       <= '0;
      s_rd          <= 1'b0;
      s_wr          <= 1'b0;
      wcnt          <= '0;
      wdog          <= '0;
      rlen          <= '0;
      cpu.cpu_rdata <= FILL_DATA;
      cpu.data_oe   <= 1'b0;
      cpu.ready_n   <= 1'b1;
      bus_err       <= 1'b0;
      halt          <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      halt    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!cpu.ads_n) begin
            state  <= DECODE;
            cyc_q  <= {cpu.mio, cpu.dc, cpu.wr};
            s_addr <= cpu.addr;
            s_be_n <= cpu.be_n;
            s_sel  <= hit;
            miss_q <= !any_hit;
            // pulses land in cycle 1, alongside DECODE
            halt   <= is_halt({cpu.mio, cpu.dc, cpu.wr});
            bus_err <= !any_hit &&
              !is_halt({cpu.mio, cpu.dc, cpu.wr});
          end
        end

        DECODE: begin
          s_wdata <= cpu.cpu_wdata;
          wdog    <= '0;
          if (halt_q) begin
            state       <= READY;
            cpu.ready_n <= 1'b0;
            cpu.data_oe <= 1'b0;
            rlen        <= '0;
          end else if (miss_q) begin
            cpu.cpu_rdata <= FILL_DATA;
            if (DEF_WAIT == 4'd0) begin
              state       <= READY;
              cpu.ready_n <= 1'b0;
              cpu.data_oe <= !wr_q;
              rlen        <= '0;
            end else begin
              state <= WAIT;
              wcnt  <= DEF_WAIT;
            end
          end else if (sel_ext) begin
            state <= EXT_REQ;
            s_rd  <= !wr_q;
            s_wr  <= wr_q;
          end else if (sel_wait == 4'd0) begin
            state       <= READY;
            cpu.ready_n <= 1'b0;
            cpu.data_oe <= !wr_q;
            rlen        <= '0;
            if (!wr_q) cpu.cpu_rdata <= sel_rdata;
          end else begin
            state <= WAIT;
            wcnt  <= sel_wait;
          end
        end

        WAIT: begin
          wdog <= wdog + 8'd1;
          if (tmo) begin
            state         <= READY;
            cpu.ready_n   <= 1'b0;
            cpu.data_oe   <= !wr_q;
            cpu.cpu_rdata <= FILL_DATA;
            rlen          <= '0;
            bus_err       <= 1'b1;
          end else if (wcnt == 4'd1) begin
            state       <= READY;
            cpu.ready_n <= 1'b0;
            cpu.data_oe <= !wr_q;
            rlen        <= '0;
            if (!wr_q && !miss_q)
              cpu.cpu_rdata <= sel_rdata;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end

        EXT_REQ: begin
          wdog <= wdog + 8'd1;
          if (tmo) begin
            s_rd          <= 1'b0;
            s_wr          <= 1'b0;
            state         <= READY;
            cpu.ready_n   <= 1'b0;
            cpu.data_oe   <= !wr_q;
            cpu.cpu_rdata <= FILL_DATA;
            rlen          <= '0;
            bus_err       <= 1'b1;
          end else if (!sel_wreq) begin
            s_rd <= 1'b0;
            s_wr <= 1'b0;
            if (wr_q) begin
              state       <= READY;
              cpu.ready_n <= 1'b0;
              cpu.data_oe <= 1'b0;
              rlen        <= '0;
            end else begin
              state <= EXT_RESP;
            end
          end
        end

        EXT_RESP: begin
          wdog <= wdog + 8'd1;
          if (tmo) begin
            state         <= READY;
            cpu.ready_n   <= 1'b0;
            cpu.data_oe   <= 1'b1;
            cpu.cpu_rdata <= FILL_DATA;
            rlen          <= '0;
            bus_err       <= 1'b1;
          end else if (sel_valid) begin
            state         <= READY;
            cpu.ready_n   <= 1'b0;
            cpu.data_oe   <= 1'b1;
            cpu.cpu_rdata <= sel_rdata;
            rlen          <= '0;
          end
        end

        READY: begin
          if (rlen == READY_LEN - 2'd1) begin
            state       <= IDLE;
            cpu.ready_n <= 1'b1;
            cpu.data_oe <= 1'b0;
          end else begin
            rlen <= rlen + 2'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sx_bus_bridge.sv
// tb_sx_bus_bridge: table-driven bench with a scoreboard
// queue and a simple external slave on region 1.
module tb_sx_bus_bridge;
  import sx_bus_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic [2:0]  cyc;
    logic [1:0]  be_n;
    logic [23:0] a;
    logic [15:0] wd;
    int          ew;
    int          vd;
    bit          ve;
    int          rdy;
    logic [15:0] d;
    int          err;
    bit          h;
    logic [3:0]  sel;
    int          rdn;
    int          wrn;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  s_sel;
  logic [22:0]   s_addr;
  logic [1:0]    s_be_n;
  logic [15:0]   s_wdata;
  logic          s_rd, s_wr;
  logic [N*16-1:0] s_rdata;
  logic [N-1:0]  s_waitrequest, s_valid;
  logic          bus_err, halt, busy;
  logic          wreq1, vld1;

  int ext_wait = 0;
  int ext_vdly = 0;
  bit ext_ven  = 1'b0;
  int wcnt     = 0;
  int vcnt     = 0;
  bit resp_pend = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t exp_q[$];
  vec_t vt[11];

  sx_bus_bridge_if bus ();

  sx_bus_bridge #(
    .N_REG    (N),
    .REG_BASE ({24'h000300, 24'h800000,
                24'h000000, 24'hFFFC00}),
    .REG_MASK ({24'hFFFF00, 24'h800000,
                24'h800000, 24'hFFFC00}),
    .REG_IO   (4'b1000),
    .REG_EXT  (4'b0010),
    .REG_WAIT ({4'd1, 4'd2, 4'd0, 4'd0}),
    .DEF_WAIT (4'd1),
    .TIMEOUT  (8'd8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu           (bus),
    .s_sel         (s_sel),
    .s_addr        (s_addr),
    .s_be_n        (s_be_n),
    .s_wdata       (s_wdata),
    .s_rd          (s_rd),
    .s_wr          (s_wr),
    .s_rdata       (s_rdata),
    .s_waitrequest (s_waitrequest),
    .s_valid       (s_valid),
    .bus_err       (bus_err),
    .halt          (halt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  assign s_rdata = {16'h3333, 16'h2222,
                    16'hA5C3, 16'hEBFE};
  assign wreq1 = (s_rd || s_wr) && (wcnt < ext_wait);
  assign vld1  = resp_pend && ext_ven && (vcnt >= ext_vdly);
  assign s_waitrequest = {2'b00, wreq1, 1'b0};
  assign s_valid       = {2'b00, vld1, 1'b0};

  // external slave on region 1
  always @(posedge clk) begin
    if (reset || !busy) begin
      wcnt      <= 0;
      vcnt      <= 0;
      resp_pend <= 1'b0;
    end else begin
      if (s_rd || s_wr) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (s_rd && !wreq1) begin
        resp_pend <= 1'b1;
        vcnt      <= 0;
      end else if (resp_pend) begin
        if (vld1) resp_pend <= 1'b0;
        vcnt <= vcnt + 1;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [2:0] cyc, input logic [1:0] be,
    input logic [23:0] a, input logic [15:0] wd,
    input int ew, input int vd, input bit ve,
    input int rdy, input logic [15:0] d,
    input int err, input bit h, input logic [3:0] sel,
    input int rdn, input int wrn);
    vec_t v;
    v.cyc = cyc; v.be_n = be; v.a = a; v.wd = wd;
    v.ew = ew; v.vd = vd; v.ve = ve;
    v.rdy = rdy; v.d = d; v.err = err; v.h = h;
    v.sel = sel; v.rdn = rdn; v.wrn = wrn;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.ads_n     = 1'b0;
    bus.mio       = v.cyc[2];
    bus.dc        = v.cyc[1];
    bus.wr        = v.cyc[0];
    bus.be_n      = v.be_n;
    bus.addr      = v.a[23:1];
    bus.cpu_wdata = v.wd;
    ext_wait      = v.ew;
    ext_vdly      = v.vd;
    ext_ven       = v.ve;
  endtask

  task automatic run_vec(input vec_t v, input string t);
    int rdy_at = -1;
    int rdy_n  = 0;
    int err_at = -1;
    int err_n  = 0;
    int h_at   = -1;
    int h_n    = 0;
    int rd_n   = 0;
    int wr_n   = 0;
    int oe_n   = 0;
    bit done   = 1'b0;
    vec_t e;
    drive(v);
    exp_q.push_back(v);
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.ads_n = 1'b1;
        chk({t, ".sel"}, 32'(s_sel), 32'(v.sel));
        chk({t, ".addr"}, 32'(s_addr), 32'(v.a[23:1]));
      end
      if (c == 2 && v.cyc[0]) begin
        chk({t, ".wdata"}, 32'(s_wdata), 32'(v.wd));
        chk({t, ".be_n"}, 32'(s_be_n), 32'(v.be_n));
      end
      if (bus_err) begin
        if (err_at < 0) err_at = c;
        err_n++;
      end
      if (halt) begin
        if (h_at < 0) h_at = c;
        h_n++;
      end
      if (s_rd) rd_n++;
      if (s_wr) wr_n++;
      if (bus.data_oe) oe_n++;
      if (!bus.ready_n) begin
        if (rdy_at < 0) begin
          rdy_at = c;
          if (exp_q.size() == 0) begin
            chk({t, ".sb_pop"}, 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk({t, ".rdy"}, rdy_at, e.rdy);
            if (!e.cyc[0])
              chk({t, ".data"},
                  32'(bus.cpu_rdata), 32'(e.d));
          end
        end
        rdy_n++;
      end else if (rdy_at >= 0) begin
        done = 1'b1;
      end
    end
    chk({t, ".done"}, 32'(done), 1);
    chk({t, ".rdy_len"}, rdy_n, 2);
    chk({t, ".oe_len"}, oe_n, v.cyc[0] ? 0 : 2);
    chk({t, ".err_at"}, err_at, v.err);
    chk({t, ".err_n"}, err_n, (v.err >= 0) ? 1 : 0);
    chk({t, ".halt_at"}, h_at, v.h ? 1 : -1);
    chk({t, ".halt_n"}, h_n, v.h ? 1 : 0);
    chk({t, ".rd_n"}, rd_n, v.rdn);
    chk({t, ".wr_n"}, wr_n, v.wrn);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // {mio,dc,wr}, be, addr, wdata, ext_wait, vdly, ven,
    // ready cycle, data, err cycle, halt, sel, rd_n, wr_n
    vt[0]  = mk(3'b110, 2'b00, 24'hFFFFF0, 16'h0000,
                0, 0, 0, 2, 16'hEBFE, -1, 0, 4'b0001, 0, 0);
    vt[1]  = mk(3'b111, 2'b01, 24'h000100, 16'h1234,
                3, 0, 0, 6, 16'h0000, -1, 0, 4'b0010, 0, 4);
    vt[2]  = mk(3'b110, 2'b00, 24'h000300, 16'h0000,
                0, 0, 1, 4, 16'hA5C3, -1, 0, 4'b0010, 1, 0);
    vt[3]  = mk(3'b110, 2'b10, 24'h000200, 16'h0000,
                2, 3, 1, 9, 16'hA5C3, -1, 0, 4'b0010, 3, 0);
    vt[4]  = mk(3'b110, 2'b00, 24'h000400, 16'h0000,
                0, 0, 0, 10, 16'hFFFF, 10, 0, 4'b0010, 1, 0);
    vt[5]  = mk(3'b111, 2'b00, 24'h000402, 16'h5A5A,
                100, 0, 0, 10, 16'h0000, 10, 0, 4'b0010, 0, 8);
    vt[6]  = mk(3'b010, 2'b00, 24'h000080, 16'h0000,
                0, 0, 0, 3, 16'hFFFF, 1, 0, 4'b0000, 0, 0);
    vt[7]  = mk(3'b101, 2'b00, 24'h000002, 16'h0000,
                0, 0, 0, 2, 16'h0000, -1, 1, 4'b0010, 0, 0);
    vt[8]  = mk(3'b110, 2'b00, 24'h900000, 16'h0000,
                0, 0, 0, 4, 16'h2222, -1, 0, 4'b0100, 0, 0);
    vt[9]  = mk(3'b011, 2'b11, 24'h000310, 16'hBEEF,
                0, 0, 0, 3, 16'h0000, -1, 0, 4'b1000, 0, 0);
    vt[10] = mk(3'b010, 2'b00, 24'h000304, 16'h0000,
                0, 0, 0, 3, 16'h3333, -1, 0, 4'b1000, 0, 0);

    reset         = 1'b1;
    bus.ads_n     = 1'b1;
    bus.mio       = 1'b0;
    bus.dc        = 1'b0;
    bus.wr        = 1'b0;
    bus.be_n      = 2'b00;
    bus.addr      = '0;
    bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready_n", 32'(bus.ready_n), 1);
    chk("rst.data_oe", 32'(bus.data_oe), 0);
    chk("rst.rdata", 32'(bus.cpu_rdata), 32'hFFFF);
    chk("rst.s_rd_wr", 32'({s_rd, s_wr}), 0);
    chk("rst.s_sel", 32'(s_sel), 0);
    chk("rst.err_halt", 32'({bus_err, halt}), 0);
    chk("rst.busy", 32'(busy), 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      run_vec(vt[i], $sformatf("v%0d", i));

    // reset while an external write is stalled
    drive(vt[5]);
    @(negedge clk);
    bus.ads_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mrst.pre_wr", 32'(s_wr), 1);
    chk("mrst.pre_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst.s_wr", 32'(s_wr), 0);
    chk("mrst.ready_n", 32'(bus.ready_n), 1);
    chk("mrst.busy", 32'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst.idle_rdy", 32'(bus.ready_n), 1);
    run_vec(vt[2], "post_rst");

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
